// File: rtl/simt_reconv_stack.sv
// simt_reconv_stack: block PC, active thread mask and divergence /
// reconvergence stack for one SIMT block, one control event per step.
module simt_reconv_stack #(
  parameter int THREADS_PER_BLOCK     = 4,
  parameter int STACK_DEPTH           = 4,
  parameter int PROGRAM_MEM_ADDR_BITS = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [$clog2(THREADS_PER_BLOCK):0]  thread_count,
  input  logic                                step,
  input  logic                                branch,
  input  logic [THREADS_PER_BLOCK-1:0]        taken_mask,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0]    branch_target,
  input  logic                                reconv,
  input  logic                                ret,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0]    current_pc,
  output logic [THREADS_PER_BLOCK-1:0]        active_mask,
  output logic [$clog2(STACK_DEPTH+1)-1:0]    depth,
  output logic                                busy,
  output logic                                done,
  output logic                                overflow
);

  localparam int T  = THREADS_PER_BLOCK;
  localparam int PW = PROGRAM_MEM_ADDR_BITS;
  localparam int DW = $clog2(STACK_DEPTH+1);
  localparam int CW = $clog2(T) + 1;
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_UNWIND,
    S_DONE,
    S_ERROR
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   pc_q, pc_d;
  logic [T-1:0]    act_q, act_d;
  logic [T-1:0]    tmask_q, tmask_d;
  logic [T-1:0]    retd_q, retd_d;
  logic [DW-1:0]   depth_q, depth_d;
  logic            ovf_q, ovf_d;

  // Stack storage; rpc holds the resume PC used when an unwind pops.
  logic [T-1:0]    res_q [STACK_DEPTH];
  logic [T-1:0]    alt_q [STACK_DEPTH];
  logic [PW-1:0]   apc_q [STACK_DEPTH];
  logic [PW-1:0]   rpc_q [STACK_DEPTH];
  logic            ph_q  [STACK_DEPTH];

  logic            push_en;
  logic            flip_en;
  logic [IW-1:0]   top_idx;
  logic [IW-1:0]   push_idx;
  logic [T-1:0]    t_res;
  logic [T-1:0]    t_alt;
  logic [PW-1:0]   t_apc;
  logic [PW-1:0]   t_rpc;
  logic            t_ph;
  logic [T-1:0]    r_eff;
  logic [T-1:0]    alt_live;
  logic [T-1:0]    res_live;
  logic [T-1:0]    br_t;
  logic [T-1:0]    br_n;
  logic [T-1:0]    start_mask;
  logic [PW-1:0]   pc_inc;
  logic            stk_empty;
  logic            stk_full;
  logic            ret_ev;

  assign top_idx   = IW'(depth_q - DW'(1));
  assign push_idx  = IW'(depth_q);
  assign t_res     = res_q[top_idx];
  assign t_alt     = alt_q[top_idx];
  assign t_apc     = apc_q[top_idx];
  assign t_rpc     = rpc_q[top_idx];
  assign t_ph      = ph_q[top_idx];
  assign stk_empty = (depth_q == '0);
  assign stk_full  = (depth_q == DW'(STACK_DEPTH));
  assign pc_inc    = pc_q + PW'(1);
  assign br_t      = taken_mask & act_q;
  assign br_n      = act_q & ~br_t;

  // A RET retires the current path before the top entry is examined.
  assign ret_ev    = (state_q == S_RUN) && step && ret;
  assign r_eff     = ret_ev ? (retd_q | act_q) : retd_q;
  assign alt_live  = t_alt & ~r_eff & tmask_q;
  assign res_live  = t_res & ~r_eff & tmask_q;

  // Thread-present mask from thread_count, saturating at all ones.
  always_comb begin
    start_mask = '0;
    for (int i = 0; i < T; i++) begin
      if (CW'(i) < thread_count) start_mask[i] = 1'b1;
    end
  end

  // Next-state: start handling, per-step events and unwinding.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    act_d   = act_q;
    tmask_d = tmask_q;
    retd_d  = retd_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    push_en = 1'b0;
    flip_en = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = '0;
          act_d   = start_mask;
          tmask_d = start_mask;
          retd_d  = '0;
          depth_d = '0;
          ovf_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (step) begin
          if (ret) begin
            retd_d = retd_q | act_q;
            if (stk_empty) begin
              act_d   = '0;
              state_d = S_DONE;
            end else if (!t_ph) begin
              flip_en = 1'b1;
              act_d   = alt_live;
              pc_d    = t_apc;
              if (alt_live == '0) state_d = S_UNWIND;
            end else begin
              depth_d = depth_q - DW'(1);
              act_d   = res_live;
              if (res_live == '0) state_d = S_UNWIND;
            end
          end else if (reconv) begin
            if (stk_empty) begin
              pc_d = pc_inc;
            end else if (!t_ph) begin
              flip_en = 1'b1;
              act_d   = alt_live;
              pc_d    = t_apc;
              if (alt_live == '0) state_d = S_UNWIND;
            end else begin
              depth_d = depth_q - DW'(1);
              act_d   = res_live;
              pc_d    = pc_inc;
              if (res_live == '0) state_d = S_UNWIND;
            end
          end else if (branch) begin
            if (br_t == '0) begin
              pc_d = pc_inc;
            end else if (br_n == '0) begin
              pc_d = branch_target;
            end else if (!stk_full) begin
              push_en = 1'b1;
              act_d   = br_t;
              pc_d    = branch_target;
              depth_d = depth_q + DW'(1);
            end else begin
              ovf_d   = 1'b1;
              state_d = S_ERROR;
            end
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      S_UNWIND: begin
        if (stk_empty) begin
          act_d   = '0;
          state_d = S_DONE;
        end else if (!t_ph) begin
          flip_en = 1'b1;
          act_d   = alt_live;
          pc_d    = t_apc;
          if (alt_live != '0) state_d = S_RUN;
        end else begin
          depth_d = depth_q - DW'(1);
          act_d   = res_live;
          pc_d    = t_rpc;
          if (res_live != '0) state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      act_q   <= '0;
      tmask_q <= '0;
      retd_q  <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      act_q   <= act_d;
      tmask_q <= tmask_d;
      retd_q  <= retd_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
    end
  end

  // Stack writes; a phase flip also records the post-RECONV PC.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (push_en) begin
        res_q[push_idx] <= act_q;
        alt_q[push_idx] <= br_n;
        apc_q[push_idx] <= pc_inc;
        rpc_q[push_idx] <= pc_inc;
        ph_q[push_idx]  <= 1'b0;
      end
      if (flip_en) begin
        ph_q[top_idx]  <= 1'b1;
        rpc_q[top_idx] <= pc_inc;
      end
    end
  end

  assign current_pc  = pc_q;
  assign active_mask = act_q;
  assign depth       = depth_q;
  assign busy        = (state_q == S_UNWIND);
  assign done        = (state_q == S_DONE) || (state_q == S_ERROR);
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_simt_reconv_stack.sv
// tb_simt_reconv_stack: directed + random stimulus, queue-based
// scoreboard against a behavioural block-control model.
module tb_simt_reconv_stack;

  localparam int SD = 2;

  logic       clk;
  logic       reset, start, step, branch, reconv, ret;
  logic [2:0] thread_count;
  logic [3:0] taken_mask;
  logic [7:0] branch_target;
  logic [7:0] current_pc;
  logic [3:0] active_mask;
  logic [1:0] depth;
  logic       busy, done, overflow;

  simt_reconv_stack #(
    .THREADS_PER_BLOCK(4),
    .STACK_DEPTH(SD),
    .PROGRAM_MEM_ADDR_BITS(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .thread_count(thread_count), .step(step),
    .branch(branch), .taken_mask(taken_mask),
    .branch_target(branch_target), .reconv(reconv),
    .ret(ret), .current_pc(current_pc),
    .active_mask(active_mask), .depth(depth),
    .busy(busy), .done(done), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] res;
    logic [3:0] alt;
    logic [7:0] apc;
    logic [7:0] rpc;
    bit         ph;
  } ent_t;

  typedef struct {
    logic [7:0] pc;
    logic [3:0] act;
    int         dep;
    bit         busy;
    bit         done;
    bit         ovf;
  } exp_t;

  localparam int M_IDLE = 0, M_RUN = 1, M_UNW = 2,
                 M_DONE = 3, M_ERR = 4;

  ent_t       stk[$];
  exp_t       expq[$];
  int         ms;
  logic [7:0] m_pc;
  logic [3:0] m_act, m_tmsk, m_ret;
  bit         m_ovf;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Resolve the top stack entry: enter its alternate path or pop it.
  // ctx 0 = RECONV (pop resumes at pc+1), 1 = RET (pc held),
  // 2 = unwind (pop resumes at the PC following the RECONV).
  task automatic top_rule(input int ctx);
    ent_t e;
    e = stk[stk.size()-1];
    if (!e.ph) begin
      stk[stk.size()-1].ph  = 1'b1;
      stk[stk.size()-1].rpc = m_pc + 8'd1;
      m_act = e.alt & ~m_ret & m_tmsk;
      m_pc  = e.apc;
    end else begin
      void'(stk.pop_back());
      m_act = e.res & ~m_ret & m_tmsk;
      if (ctx == 0) m_pc = m_pc + 8'd1;
      else if (ctx == 2) m_pc = e.rpc;
    end
  endtask

  task automatic model(input bit rs, st, input logic [2:0] tc,
                       input bit sp, br, input logic [3:0] tm,
                       input logic [7:0] tg, input bit rc, rt);
    logic [3:0] t, n;
    exp_t x;
    if (rs) begin
      ms = M_IDLE; m_pc = 0; m_act = 0; m_ret = 0;
      m_ovf = 0; m_tmsk = 0; stk.delete();
    end else if (ms == M_IDLE || ms == M_DONE || ms == M_ERR) begin
      if (st) begin
        ms = M_RUN; m_pc = 0;
        m_tmsk = (tc >= 4) ? 4'hF : 4'((1 << tc) - 1);
        m_act = m_tmsk; m_ret = 0; m_ovf = 0; stk.delete();
      end
    end else if (ms == M_RUN) begin
      if (sp) begin
        if (rt) begin
          m_ret = m_ret | m_act;
          if (stk.size() == 0) begin
            m_act = 0; ms = M_DONE;
          end else begin
            top_rule(1);
            if (m_act == 0) ms = M_UNW;
          end
        end else if (rc) begin
          if (stk.size() == 0) m_pc = m_pc + 8'd1;
          else begin
            top_rule(0);
            if (m_act == 0) ms = M_UNW;
          end
        end else if (br) begin
          t = tm & m_act;
          n = m_act & ~t;
          if (t == 0) m_pc = m_pc + 8'd1;
          else if (n == 0) m_pc = tg;
          else if (stk.size() < SD) begin
            stk.push_back('{res: m_act, alt: n,
                            apc: m_pc + 8'd1, rpc: 8'd0, ph: 1'b0});
            m_act = t; m_pc = tg;
          end else begin
            m_ovf = 1; ms = M_ERR;
          end
        end else begin
          m_pc = m_pc + 8'd1;
        end
      end
    end else begin
      if (stk.size() == 0) begin
        ms = M_DONE; m_act = 0;
      end else begin
        top_rule(2);
        if (m_act != 0) ms = M_RUN;
      end
    end
    x.pc = m_pc; x.act = m_act; x.dep = stk.size();
    x.busy = (ms == M_UNW);
    x.done = (ms == M_DONE) || (ms == M_ERR);
    x.ovf = m_ovf;
    expq.push_back(x);
  endtask

  // Drive one cycle of inputs and queue the expected outputs.
  task automatic cyc_in(input bit rs, st, input logic [2:0] tc,
                        input bit sp, br, input logic [3:0] tm,
                        input logic [7:0] tg, input bit rc, rt);
    @(negedge clk);
    reset = rs; start = st; thread_count = tc; step = sp;
    branch = br; taken_mask = tm; branch_target = tg;
    reconv = rc; ret = rt;
    model(rs, st, tc, sp, br, tm, tg, rc, rt);
  endtask

  task automatic do_rst();  cyc_in(1,0,0,0,0,0,0,0,0); endtask
  task automatic do_idle(); cyc_in(0,0,0,0,0,0,0,0,0); endtask
  task automatic do_start(input logic [2:0] tc);
    cyc_in(0,1,tc,0,0,0,0,0,0);
  endtask
  task automatic plain(input int k);
    for (int i = 0; i < k; i++) cyc_in(0,0,0,1,0,0,0,0,0);
  endtask
  task automatic brn(input logic [3:0] tm, input logic [7:0] tg);
    cyc_in(0,0,0,1,1,tm,tg,0,0);
  endtask
  task automatic rcv(); cyc_in(0,0,0,1,0,0,0,1,0); endtask
  task automatic rtn(); cyc_in(0,0,0,1,0,0,0,0,1); endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL cyc=%0d %s got=%0h expected=%0h",
               cyc, nm, got, exp);
    end
  endtask

  // Monitor: one expected record per clock once stimulus is running.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("pc", 32'(current_pc), 32'(e.pc));
      chk("mask", 32'(active_mask), 32'(e.act));
      chk("depth", 32'(depth), 32'(e.dep));
      chk("busy", 32'(busy), 32'(e.busy));
      chk("done", 32'(done), 32'(e.done));
      chk("overflow", 32'(overflow), 32'(e.ovf));
    end
  end

  initial begin
    reset = 1; start = 0; thread_count = 0; step = 0;
    branch = 0; taken_mask = 0; branch_target = 0;
    reconv = 0; ret = 0;
    ms = M_IDLE; m_pc = 0; m_act = 0; m_ret = 0;
    m_ovf = 0; m_tmsk = 0;

    do_rst(); do_rst();
    do_start(3'd3); plain(4);

    rtn(); do_start(3'd4); plain(2);
    brn(4'b0011, 8'd9); plain(3);
    rcv(); plain(9); rcv();

    rtn(); do_start(3'd4);
    brn(4'b0111, 8'd5);
    brn(4'b0011, 8'd7);
    brn(4'b0001, 8'd9);
    do_idle(); do_start(3'd4);

    plain(5); brn(4'b1111, 8'd20);
    rtn(); do_start(3'd4); plain(5); brn(4'b0000, 8'd20);

    rtn(); do_start(3'd4);
    brn(4'b0011, 8'd9);
    rtn(); rtn();
    cyc_in(0,1,3'd2,1,1,4'b0101,8'd30,0,0);
    do_idle();

    do_start(3'd4);
    brn(4'b0011, 8'd9);
    rtn(); rtn();
    do_rst(); do_idle();

    do_start(3'd7); plain(2); rtn();

    for (int i = 0; i < 3000; i++) begin
      cyc_in($urandom_range(0, 199) == 0,
             $urandom_range(0, 14) == 0,
             3'($urandom_range(0, 7)),
             $urandom_range(0, 9) < 7,
             $urandom_range(0, 2) == 0,
             4'($urandom),
             8'($urandom),
             $urandom_range(0, 4) == 0,
             $urandom_range(0, 9) == 0);
    end
    do_idle();

    for (int i = 0; i < 20 && expq.size() > 0; i++) @(posedge clk);
    #3;
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
